// File: rtl/pwm_cfg_pkg.sv
// Shared types, CTRL/DUTY register layout and word formatting
// for the PWM configuration sequencer.
package pwm_cfg_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [1:0] W0 = 2'd0;
    localparam logic [1:0] W1 = 2'd1;
    localparam logic [1:0] W2 = 2'd2;

    localparam int PERIOD_LSB = 16;
    localparam int PRESC_LSB  = 3;
    localparam int TMR_EN     = 2;
    localparam int PRE_EN     = 1;
    localparam int RST        = 0;

    localparam logic [31:0] OFS_CTRL = 32'd0;
    localparam logic [31:0] OFS_DUTY = 32'd1;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_SLV = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] duty;
        logic [4:0]  prescale;
        logic        pre_en;
        logic        tmr_en;
        logic        duty_only;
    } cfg_t;

    // The reset bit is never set: the timer must keep its count.
    function automatic logic [31:0] ctrl_word(cfg_t c, logic tmr);
        logic [31:0] w;
        w = '0;
        w[PERIOD_LSB +: 16] = c.period;
        w[PRESC_LSB +: 5]   = c.prescale;
        w[TMR_EN]           = tmr;
        w[PRE_EN]           = c.pre_en;
        w[RST]              = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] step_data(cfg_t c, logic [1:0] step);
        logic [31:0] w;
        w = '0;
        case (step)
            W0:      w = ctrl_word(c, 1'b0);
            W1:      w[15:0] = c.duty;
            W2:      w = ctrl_word(c, c.tmr_en);
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] step_addr(logic [31:0] base, logic [1:0] step);
        return (step == W1) ? (base | OFS_DUTY) : (base | OFS_CTRL);
    endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// Core-side config handshake plus APB3 write port of the sequencer.
interface pwm_cfg_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic [4:0]  cfg_prescale;
    logic        cfg_pre_en;
    logic        cfg_tmr_en;
    logic        cfg_duty_only;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [31:0] PADDR;
    logic        PSEL_pwm;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        input  cfg_valid, cfg_period, cfg_duty, cfg_prescale,
        input  cfg_pre_en, cfg_tmr_en, cfg_duty_only,
        output cfg_ready, done_o, err_o, err_code_o,
        output PADDR, PSEL_pwm, PENABLE, PWRITE, PWDATA,
        input  PREADY, PSLVERR
    );

    modport slave (
        output cfg_valid, cfg_period, cfg_duty, cfg_prescale,
        output cfg_pre_en, cfg_tmr_en, cfg_duty_only,
        input  cfg_ready, done_o, err_o, err_code_o,
        input  PADDR, PSEL_pwm, PENABLE, PWRITE, PWDATA,
        output PREADY, PSLVERR
    );
endinterface

// File: rtl/pwm_cfg_sequencer_apb3_wr_master.sv
// Single APB3 write engine: registered bus outputs, wait counter,
// and per-access completion (ok / slave error / timeout) flags.
module apb3_wr_master
    import pwm_cfg_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  state_t      i_state,
    input  state_t      i_state_nxt,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_pready,
    input  logic        i_pslverr,
    output logic        o_ok,
    output logic        o_slverr,
    output logic        o_tmo,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata
);
    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

    logic [7:0]  r_wait;
    logic        r_psel;
    logic        r_penable;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        w_access;

    assign w_access = (i_state == S_ACCESS);
    assign o_ok     = w_access && i_pready && !i_pslverr;
    assign o_slverr = w_access && i_pready && i_pslverr;
    // Fires on the TIMEOUT-th low-PREADY cycle of the access.
    assign o_tmo    = w_access && !i_pready
                      && (r_wait == WAIT_MAX - 8'd1);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_wait    <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            r_psel    <= (i_state_nxt == S_SETUP)
                         || (i_state_nxt == S_ACCESS);
            r_penable <= (i_state_nxt == S_ACCESS);
            if (i_state_nxt == S_SETUP) begin
                r_paddr  <= i_addr;
                r_pwdata <= i_data;
            end
            if (i_state == S_SETUP) begin
                r_wait <= '0;
            end else if (w_access && !i_pready && r_wait != WAIT_MAX) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_psel;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Captures one PWM configuration and replays it as the ordered
// CTRL(off) / DUTY / CTRL(final) APB write sequence.
module pwm_cfg_sequencer
    import pwm_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 16
) (
    input logic                 PCLK,
    input logic                 PRESETn,
    pwm_cfg_sequencer_if.master bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_step;
    logic [1:0]  w_step_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_nxt;
    cfg_t        r_cfg;
    cfg_t        w_cfg_in;
    cfg_t        w_cfg;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic        w_ok;
    logic        w_slverr;
    logic        w_tmo;
    logic        w_last;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_psel;
    logic        w_penable;
    logic        w_pwrite;
    logic [31:0] w_paddr;
    logic [31:0] w_pwdata;

    assign w_cfg_in = '{
        period:    bus.cfg_period,
        duty:      bus.cfg_duty,
        prescale:  bus.cfg_prescale,
        pre_en:    bus.cfg_pre_en,
        tmr_en:    bus.cfg_tmr_en,
        duty_only: bus.cfg_duty_only
    };

    // The first SETUP word is formatted from the live inputs.
    assign w_cfg  = (r_state == S_IDLE) ? w_cfg_in : r_cfg;
    assign w_last = r_cfg.duty_only || (r_step == W2);
    assign w_addr = step_addr(BASE_ADDR, w_step_nxt);
    assign w_data = step_data(w_cfg, w_step_nxt);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_err_nxt   = r_err_code;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    w_state_nxt = S_SETUP;
                    w_step_nxt  = bus.cfg_duty_only ? W1 : W0;
                    w_err_nxt   = ERR_OK;
                end
            end
            S_SETUP: w_state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (w_slverr) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = ERR_SLV;
                end else if (w_ok && w_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_ok) begin
                    w_state_nxt = S_SETUP;
                    w_step_nxt  = r_step + 2'd1;
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = ERR_TMO;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_step     <= W0;
            r_cfg      <= '0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_OK;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            if (r_state == S_IDLE && bus.cfg_valid) begin
                r_cfg <= w_cfg_in;
            end
            r_ready    <= (w_state_nxt == S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_DONE) && (w_err_nxt != ERR_OK);
            r_err_code <= w_err_nxt;
        end
    end

    apb3_wr_master #(
        .TIMEOUT (TIMEOUT)
    ) u_apb (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .i_state     (r_state),
        .i_state_nxt (w_state_nxt),
        .i_addr      (w_addr),
        .i_data      (w_data),
        .i_pready    (bus.PREADY),
        .i_pslverr   (bus.PSLVERR),
        .o_ok        (w_ok),
        .o_slverr    (w_slverr),
        .o_tmo       (w_tmo),
        .o_psel      (w_psel),
        .o_penable   (w_penable),
        .o_pwrite    (w_pwrite),
        .o_paddr     (w_paddr),
        .o_pwdata    (w_pwdata)
    );

    assign bus.cfg_ready  = r_ready;
    assign bus.done_o     = r_done;
    assign bus.err_o      = r_err;
    assign bus.err_code_o = r_err_code;
    assign bus.PSEL_pwm   = w_psel;
    assign bus.PENABLE    = w_penable;
    assign bus.PWRITE     = w_pwrite;
    assign bus.PADDR      = w_paddr;
    assign bus.PWDATA     = w_pwdata;

endmodule

// File: doc/pwm_cfg_sequencer.md
# pwm_cfg_sequencer

APB3 write-master that configures the PWM peripheral slave on behalf of the core. Accepts one whole PWM configuration (period, duty, prescaler, enables) over a valid/ready handshake and issues the ordered APB write sequence that reprograms the timer without glitching. Reports completion or bus error back to the requester. Sits between the core-side control logic and the PWM slave's APB port (PSEL_pwm).

## Interface
- BASE_ADDR, 32'h0000_0000: PWM slave base address; bit 0 must be 0.
- TIMEOUT, 16: maximum ACCESS cycles allowed while waiting for PREADY; range 1..255.
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  sequencer idle and able to accept.
- cfg_period  in  16  PWM period value.
- cfg_duty  in  16  PWM duty value.
- cfg_prescale  in  5  prescaler value.
- cfg_pre_en  in  1  prescaler enable.
- cfg_tmr_en  in  1  timer enable after the update.
- cfg_duty_only  in  1  only rewrite the duty register.
- done_o  out  1  one-cycle pulse at the end of a sequence.
- err_o  out  1  qualifies done_o: sequence aborted.
- err_code_o  out  2  01 = PSLVERR, 10 = timeout, 00 = ok; held until the next accept.
- PADDR  out  32  APB address.
- PSEL_pwm  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  always 1 while PSEL_pwm is high, else 0.
- PWDATA  out  32  APB write data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error; sampled only with PREADY in ACCESS.

## Operation
- Register words:
  - CTRL is at BASE_ADDR and holds [31:16] period, [7:3] prescale, [2] tmr_en, [1] pre_en, [0] rst. Bit 0 is always written 0. All other bits are 0.
  - DUTY is at BASE_ADDR|1 and holds [15:0] duty; upper bits are 0.
- Accept: when cfg_valid && cfg_ready, all cfg_* inputs are captured into internal registers. The inputs are ignored afterwards.
- Full sequence (cfg_duty_only=0), three writes:
  - W0: CTRL with new period, prescale and pre_en, tmr_en=0.
  - W1: DUTY.
  - W2: CTRL identical to W0 but tmr_en=cfg_tmr_en.
- Duty-only sequence (cfg_duty_only=1): W1 only.
- FSM states are IDLE, SETUP, ACCESS and DONE. A 2-bit step index selects W0/W1/W2.
  - IDLE: cfg_ready=1. On accept, go to SETUP with step = duty_only ? 1 : 0.
  - SETUP: PSEL_pwm=1, PENABLE=0, PADDR/PWDATA per step. Always go to ACCESS next.
  - ACCESS: PSEL_pwm=1, PENABLE=1, address and data held stable.
    - PREADY && PSLVERR: go to DONE with err 01.
    - PREADY && !PSLVERR, last step: go to DONE, ok.
    - PREADY && !PSLVERR, otherwise: step+1, go to SETUP. Back-to-back writes have no idle cycle.
    - No PREADY and the wait counter reaches TIMEOUT: go to DONE with err 10. PSEL_pwm and PENABLE drop.
  - DONE: done_o=1 and err_o set per err_code_o. cfg_ready=0. Go to IDLE.
- An error aborts the remaining steps. The timer may be left disabled; this is intentional.
- The wait counter clears on entry to ACCESS. It counts cycles with PREADY low and saturates at TIMEOUT.
- In IDLE and DONE: PSEL_pwm, PENABLE and PWRITE are 0. PADDR and PWDATA hold their last values.

## Timing
- Reset values: state IDLE, cfg_ready=1 (the cycle after reset), done_o=0, err_o=0, err_code_o=00, PSEL_pwm=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- Reset asserted in any state returns to IDLE on that edge. No done_o pulse. The captured config is discarded. An in-flight APB transfer is dropped.
- All outputs are registered.
- Zero-wait slave, full sequence, accept at edge 0:
  - SETUP/ACCESS pairs in cycles 1/2, 3/4 and 5/6.
  - done_o in cycle 7; cfg_ready high in cycle 8.
  - Latency is therefore 7 cycles to done.
- Zero-wait slave, duty-only: done_o in cycle 3.
- Each PREADY wait state adds one cycle.
- A timeout gives done_o TIMEOUT+1 cycles after ACCESS entry.
- cfg_valid asserted during DONE is not accepted until IDLE.

## Structure
- Package pwm_cfg_pkg contains:
  - the state enum;
  - step constants W0/W1/W2;
  - CTRL bit-field positions (PERIOD_LSB=16, PRESC_LSB=3, TMR_EN=2, PRE_EN=1, RST=0);
  - register offsets (CTRL=0, DUTY=1);
  - error codes.
- Sub-module apb3_wr_master performs a single APB3 write with the SETUP/ACCESS/timeout logic. It returns a done/err pulse.
- pwm_cfg_sequencer holds the capture registers, the step index and the word formatting.

## Test plan
- Full config with period=16'h0100, duty=16'h0040, prescale=5'd3, pre_en=1, tmr_en=1 against a zero-wait slave:
  - writes in order CTRL=32'h0100_001A, DUTY=32'h0000_0040, CTRL=32'h0100_001E;
  - done_o in cycle 7 with err_o=0.
- Duty-only with duty=16'h0080: exactly one write, DUTY=32'h0000_0080, with done_o 3 cycles after accept.
- PREADY held low for 2 cycles on W1: ACCESS is extended with PADDR and PWDATA stable, and done_o arrives at cycle 9.
- PSLVERR=1 with PREADY on W0: no W1 or W2 is issued, done_o=1, err_o=1, err_code_o=01.
- PREADY held low forever with TIMEOUT=4: PSEL_pwm drops after 4 ACCESS cycles, err_code_o=10, and cfg_ready returns.
- PRESETn low during the ACCESS of W1: the next cycle has all APB outputs at 0, no done_o, and cfg_ready=1 after release.
